posit_to_float: RTL
===================

// Module: posit_to_float
// PURPOSE
// - Pipelined decoder: converts a posit<N,es> word (as produced by the posit adders) into an IEEE-754 binary float.
// - Sits on the posit result path for host readback of PairHMM scores.
// - Streaming, one conversion per cycle, fixed latency, no backpressure (same start/done style as the posit adders).
// PARAMETERS
// - N   32  posit width
// - es  2   posit exponent field width
// - FE  8   float exponent width
// - FM  23  float fraction width
// - Bs  log2(N)  derived; not to be overridden
// - Legal configs: (N-2)*2^es <= 2^(FE-1)-2, so all posit scales map to normal floats (no denormals, no overflow)
// PORTS
// - aclk    in   1        clock; all logic on posedge
// - reset   in   1        synchronous, active-high
// - in      in   N        posit operand; sampled when start=1
// - start   in   1        operand valid strobe
// - result  out  1+FE+FM  float result
// - inf     out  1        result is NaR (in == 1000...0)
// - zero    out  1        result is zero (in == 0)
// - done    out  1        result/inf/zero valid this cycle
// BEHAVIOUR
// - Reset: done=0, result=0, inf=0, zero=0; all in-flight valid bits cleared.
// - Latency 3: start at edge t -> done=1 at edge t+3. Throughput: 1 per cycle; start may be high every cycle.
// - S1: register in and valid; s = in[N-1]; detect zero/NaR; x = s ? -in : in.
// - S2: leading-run count on x[N-2:0] -> regime k (run of m ones: k=m-1; run of m zeros: k=-m);
//   e = next es bits (zero-padded if truncated); frac = remaining bits, left-aligned to N-es-3 bits.
// - S3: scale = k*2^es + e (signed, es+Bs+2 bits); float exp = scale + 2^(FE-1)-1;
//   fraction reduced to FM bits per rounding mode; sign = s.
// - Outputs update only on cycles with done=1; otherwise hold their last value.
// - Zero: result=0, zero=1, inf=0. NaR: result = quiet NaN (sign 0, exp all ones, MSB fraction 1), inf=1, zero=0.
// - Rounding carry out of the fraction increments the float exponent (fraction becomes 0); cannot overflow under the legal-config rule.
// - Reset asserted while operands are in flight: those operands are dropped and done is never raised for them;
//   starts on the first cycle after reset are processed normally.
// - No stall input: a downstream consumer must accept every done pulse.
// CONFIGURATION
// - POSIT2FLOAT_RNE_EN defined: round-to-nearest-even on the dropped fraction bits (guard, sticky, LSB).
// - Not defined: truncation (dropped bits discarded). Latency is identical in both builds.
// STRUCTURE
// - posit_pkg (shared with the adders): log2 function, NAR/zero pattern helpers,
//   float field widths, quiet-NaN constant, scale-width localparams.
// - One sub-module, posit_field_decode (combinational, used in S2): in x[N-2:0]; out k, e, frac.
//   Reusable by the adders in place of their own field-extraction logic.
// - Pipeline stage registers stay in posit_to_float.
// TESTING (N=32, es=2, float32)
// - 0x40000000 -> 0x3F800000 (1.0); 0xC0000000 -> 0xBF800000; 0x48000000 -> 0x40000000 (2.0)
// - 0x00000000 -> 0x00000000, zero=1; 0x80000000 -> 0x7FC00000, inf=1
// - maxpos 0x7FFFFFFF -> 0x7B800000 (2^120); minpos 0x00000001 -> 0x03800000 (2^-120)
// - RNE build: 0x40000001 -> 0x3F800000; 0x40000008 -> 0x3F800000 (tie, even);
//   0x40000018 -> 0x3F800002; 0x4000000C -> 0x3F800001.
//   Truncate build: 0x4000000C -> 0x3F800000.
// - 1000 random back-to-back starts vs reference model: done exactly 3 cycles after each start, values bit-exact
// - Starts on 3 consecutive cycles, reset pulsed on the cycle after the 2nd start
//   -> no done for any of the 3; outputs all 0; next start completes normally

Source files
------------

// File: rtl/posit_pkg.sv
// posit_pkg: constants and helpers shared by the posit datapath blocks
// (adders and the posit-to-float decoder).
package posit_pkg;

  // Default posit<32,2> operand and binary32 result geometry.
  localparam int unsigned PositW     = 32;
  localparam int unsigned PositEs    = 2;
  localparam int unsigned FloatExpW  = 8;
  localparam int unsigned FloatFracW = 23;

  // Widest word the pattern helpers can describe.
  localparam int unsigned MaxPatW = 64;

  // Ceiling log2, used for run-length and regime widths.
  function automatic int unsigned log2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) begin
      r++;
    end
    return r;
  endfunction

  // Signed scale k*2^es + e needs es+log2(N)+2 bits.
  function automatic int unsigned scale_width(input int unsigned es_w, input int unsigned n);
    return es_w + log2(n) + 2;
  endfunction

  // Total float width: sign + exponent + fraction.
  function automatic int unsigned float_width(input int unsigned fe, input int unsigned fm);
    return 1 + fe + fm;
  endfunction

  // NaR is a lone sign bit.
  function automatic logic [MaxPatW-1:0] nar_pattern(input int unsigned n);
    return MaxPatW'(1) << (n - 1);
  endfunction

  // Posit zero is the all-zeros word.
  function automatic logic [MaxPatW-1:0] zero_pattern();
    return '0;
  endfunction

  // Quiet NaN: sign 0, exponent all ones, fraction MSB set.
  function automatic logic [MaxPatW-1:0] qnan_pattern(input int unsigned fe,
                                                      input int unsigned fm);
    logic [MaxPatW-1:0] exp_ones;
    exp_ones = (MaxPatW'(1) << fe) - MaxPatW'(1);
    return (exp_ones << fm) | (MaxPatW'(1) << (fm - 1));
  endfunction

endpackage

// File: rtl/posit_field_decode.sv
// posit_field_decode: combinational field extraction for a posit magnitude.
// Takes the N-1 bits below the sign of a non-negative posit and returns the
// regime k, the exponent e (zero-padded when cut short) and the fraction
// left-aligned to N-es-3 bits.
module posit_field_decode
  import posit_pkg::*;
#(
  parameter int unsigned N  = PositW,
  parameter int unsigned es = PositEs
) (
  input  logic [N-2:0]        i_x,
  output logic signed [log2(N):0] o_k,
  output logic [es-1:0]       o_e,
  output logic [N-es-4:0]     o_frac
);

  localparam int unsigned Bs    = log2(N);
  localparam int unsigned W     = N - 1;
  localparam int unsigned FracW = N - es - 3;

  logic [W-1:0]  w_inv;
  logic [Bs-1:0] w_run;
  logic          w_found;
  logic [Bs-1:0] w_shamt;
  logic [Bs:0]   w_run_ext;
  logic [W-3:0]  w_body;

  // A run of ones becomes a run of zeros so one leading-zero count serves both.
  assign w_inv = i_x[W-1] ? ~i_x : i_x;

  // Leading-run length m; an all-run word (maxpos/minpos) gives m = N-1.
  always_comb begin
    w_run   = Bs'(W);
    w_found = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      if (!w_found && w_inv[i]) begin
        w_found = 1'b1;
        w_run   = Bs'(W - 1 - i);
      end
    end
  end

  // Run plus terminator is at least two bits, so dropping the top two bits
  // and shifting by m-1 lines up exponent and fraction without waste.
  assign w_shamt = w_run - Bs'(1);
  assign w_body  = i_x[W-3:0] << w_shamt;

  assign o_e    = w_body[W-3 -: es];
  assign o_frac = w_body[FracW-1:0];

  // Ones run of m: k = m-1; zeros run of m: k = -m.
  assign w_run_ext = {1'b0, w_run};
  assign o_k = i_x[W-1] ? (w_run_ext - (Bs+1)'(1)) : ((Bs+1)'(0) - w_run_ext);

endmodule

// File: rtl/posit_to_float.sv
// posit_to_float: three-stage streaming posit<N,es> to IEEE-754 float decoder.
// One conversion per cycle, done three cycles after start, no backpressure.
// Build option: define POSIT2FLOAT_RNE_EN for round-to-nearest-even on the
// dropped fraction bits; otherwise the fraction is truncated.
module posit_to_float
  import posit_pkg::*;
#(
  parameter int unsigned N  = PositW,
  parameter int unsigned es = PositEs,
  parameter int unsigned FE = FloatExpW,
  parameter int unsigned FM = FloatFracW
) (
  input  logic             aclk,
  input  logic             reset,
  input  logic [N-1:0]     in,
  input  logic             start,
  output logic [FE+FM:0]   result,
  output logic             inf,
  output logic             zero,
  output logic             done
);

  localparam int unsigned Bs     = log2(N);
  localparam int unsigned FracW  = N - es - 3;
  localparam int unsigned ScaleW = scale_width(es, N);
  localparam int unsigned FW     = float_width(FE, FM);
  localparam int unsigned Bias   = (1 << (FE - 1)) - 1;

  localparam logic [N-1:0]  NarPat  = N'(nar_pattern(N));
  localparam logic [N-1:0]  ZeroPat = N'(zero_pattern());
  localparam logic [FW-1:0] QNaN    = FW'(qnan_pattern(FE, FM));

  // ---------------- S1: capture operand, classify, take magnitude
  logic [N-2:0] w_mag;
  logic         w_is_zero;
  logic         w_is_nar;

  logic         r1_valid;
  logic         r1_sign;
  logic         r1_zero;
  logic         r1_nar;
  logic [N-2:0] r1_mag;

  // Low N-1 bits of -in equal the two's complement of the low N-1 bits.
  assign w_mag     = in[N-1] ? (~in[N-2:0] + (N-1)'(1)) : in[N-2:0];
  assign w_is_zero = (in == ZeroPat);
  assign w_is_nar  = (in == NarPat);

  // S1 register: operand magnitude and class flags.
  always_ff @(posedge aclk) begin
    if (reset) begin
      r1_valid <= 1'b0;
      r1_sign  <= 1'b0;
      r1_zero  <= 1'b0;
      r1_nar   <= 1'b0;
      r1_mag   <= '0;
    end else begin
      r1_valid <= start;
      r1_sign  <= in[N-1];
      r1_zero  <= w_is_zero;
      r1_nar   <= w_is_nar;
      r1_mag   <= w_mag;
    end
  end

  // ---------------- S2: regime / exponent / fraction extraction
  logic signed [Bs:0] w_k;
  logic [es-1:0]      w_e;
  logic [FracW-1:0]   w_frac;

  posit_field_decode #(
    .N  (N),
    .es (es)
  ) u_field_decode (
    .i_x    (r1_mag),
    .o_k    (w_k),
    .o_e    (w_e),
    .o_frac (w_frac)
  );

  logic               r2_valid;
  logic               r2_sign;
  logic               r2_zero;
  logic               r2_nar;
  logic signed [Bs:0] r2_k;
  logic [es-1:0]      r2_e;
  logic [FracW-1:0]   r2_frac;

  // S2 register: decoded fields travel with the class flags.
  always_ff @(posedge aclk) begin
    if (reset) begin
      r2_valid <= 1'b0;
      r2_sign  <= 1'b0;
      r2_zero  <= 1'b0;
      r2_nar   <= 1'b0;
      r2_k     <= '0;
      r2_e     <= '0;
      r2_frac  <= '0;
    end else begin
      r2_valid <= r1_valid;
      r2_sign  <= r1_sign;
      r2_zero  <= r1_zero;
      r2_nar   <= r1_nar;
      r2_k     <= w_k;
      r2_e     <= w_e;
      r2_frac  <= w_frac;
    end
  end

  // ---------------- S3: scale, bias, fraction reduction
  logic signed [ScaleW-1:0] w_scale;
  logic [FracW+FM-1:0]      w_frac_wide;
  logic [FM-1:0]            w_kept;
  logic [FracW-1:0]         w_dropped;
  logic                     w_round_up;
  logic                     w_carry;
  logic [FM-1:0]            w_frac_rnd;
  logic [FE-1:0]            w_exp;

  // k*2^es + e is k with e appended, since e only fills the low es bits.
  assign w_scale = {r2_k[Bs], r2_k, r2_e};

  // Padding below the fraction makes narrow posit fractions work as well.
  assign w_frac_wide = {r2_frac, {FM{1'b0}}};
  assign w_kept      = w_frac_wide[FracW+FM-1 -: FM];
  assign w_dropped   = w_frac_wide[FracW-1:0];

`ifdef POSIT2FLOAT_RNE_EN
  // Round up when above half, or exactly half with an odd kept LSB.
  assign w_round_up = w_dropped[FracW-1] & ((|w_dropped[FracW-2:0]) | w_kept[0]);
`else
  logic w_unused_dropped;
  assign w_round_up       = 1'b0;
  assign w_unused_dropped = ^w_dropped;
`endif

  // A carry out of the fraction leaves it zero and bumps the exponent.
  assign {w_carry, w_frac_rnd} = {1'b0, w_kept} + (FM+1)'(w_round_up);
  assign w_exp = FE'(w_scale) + FE'(Bias) + FE'(w_carry);

  logic          r_done;
  logic [FW-1:0] r_result;
  logic          r_inf;
  logic          r_zero;

  // Output register: updates only when a conversion completes, else holds.
  always_ff @(posedge aclk) begin
    if (reset) begin
      r_done   <= 1'b0;
      r_result <= '0;
      r_inf    <= 1'b0;
      r_zero   <= 1'b0;
    end else begin
      r_done <= r2_valid;
      if (r2_valid) begin
        if (r2_zero) begin
          r_result <= '0;
          r_inf    <= 1'b0;
          r_zero   <= 1'b1;
        end else if (r2_nar) begin
          r_result <= QNaN;
          r_inf    <= 1'b1;
          r_zero   <= 1'b0;
        end else begin
          r_result <= {r2_sign, w_exp, w_frac_rnd};
          r_inf    <= 1'b0;
          r_zero   <= 1'b0;
        end
      end
    end
  end

  assign result = r_result;
  assign inf    = r_inf;
  assign zero   = r_zero;
  assign done   = r_done;

endmodule
